// File: rtl/mem_io_responder_if.sv
// -----------------------------------------------------------------------------
// mem_io_responder_if
// Byte-wide CPU memory bus between the CPU core (master) and the memory / I/O
// responder (slave).
//   en_in          : CPU running; requests only count while high
//   a_in[31:0]     : request address
//   d_in[7:0]      : write data
//   wr_in          : 1 = write, 0 = read
//   d_out[7:0]     : registered read data back to the CPU
//   io_buffer_full : TX FIFO near-full, lets the CPU throttle UART writes
// -----------------------------------------------------------------------------
interface mem_io_responder_if;
  logic        en_in;
  logic [31:0] a_in;
  logic [7:0]  d_in;
  logic        wr_in;
  logic [7:0]  d_out;
  logic        io_buffer_full;

  modport master (
    output en_in, a_in, d_in, wr_in,
    input  d_out, io_buffer_full
  );

  modport slave (
    input  en_in, a_in, d_in, wr_in,
    output d_out, io_buffer_full
  );
endinterface

// File: rtl/mem_io_responder.sv
// -----------------------------------------------------------------------------
// mem_io_responder
// Target side of the CPU byte bus: 2**RAM_AW bytes of RAM plus an I/O window
// selected by a_in[17:16] == 2'b11 (offset a_in[2:0]):
//   off 0 : read = UART RX byte (pops it), write = push byte to TX FIFO
//   off 4 : read = run counter byte 0 (snapshots all 32 bits),
//           write = push 0x00 stop marker and raise program_stop
//   off 5-7 : read = snapshot bytes 1..3
// Ports:
//   clk_in, rst_in (async, active-low)
//   bus          : CPU bus (slave modport of mem_io_responder_if)
//   rx_data/rx_valid/rx_pop   : UART receive side
//   tx_data/tx_valid/tx_ready : UART transmit side, head of the TX FIFO
//   program_stop, tx_overflow : sticky status flags, cleared only by reset
// TXQ_DEPTH must be a power of two and at least 4.
// -----------------------------------------------------------------------------
module mem_io_responder #(
  parameter int RAM_AW    = 17,
  parameter int TXQ_DEPTH = 8
) (
  input  logic              clk_in,
  input  logic              rst_in,
  mem_io_responder_if.slave bus,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_pop,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              program_stop,
  output logic              tx_overflow
);

  localparam int PW = $clog2(TXQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(TXQ_DEPTH);
  localparam logic [CW-1:0] CNT_NEAR = CW'(TXQ_DEPTH - 2);

  logic              is_io_s;
  logic              rd_req_s;
  logic              wr_req_s;
  logic [2:0]        off_s;
  logic [RAM_AW-1:0] ram_addr_s;
  logic              push_req_s;
  logic              push_ok_s;
  logic              pop_s;
  logic [7:0]        push_byte_s;
  logic              unused_s;

  logic [7:0]        ram_q  [0:(2**RAM_AW)-1];
  logic [7:0]        fifo_q [0:TXQ_DEPTH-1];

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [31:0]       snap_q, snap_d;
  logic [7:0]        d_out_q, d_out_d;
  logic              rx_pop_q, rx_pop_d;
  logic              io_full_q;
  logic              stop_q, stop_d;
  logic              ovf_q, ovf_d;

  // Request decode; bits 31:18 and 15:3 do not take part in I/O selection.
  assign is_io_s    = (bus.a_in[17:16] == 2'b11);
  assign off_s      = bus.a_in[2:0];
  assign ram_addr_s = bus.a_in[RAM_AW-1:0];
  assign rd_req_s   = bus.en_in & ~bus.wr_in;
  assign wr_req_s   = bus.en_in & bus.wr_in;
  assign unused_s   = ^bus.a_in[31:18];

  // A zero byte written to offset 0 is treated as "nothing to send".
  assign push_req_s  = wr_req_s & is_io_s &
                       (((off_s == 3'd0) & (bus.d_in != 8'h00)) | (off_s == 3'd4));
  assign push_byte_s = (off_s == 3'd4) ? 8'h00 : bus.d_in;
  assign pop_s       = (count_q != CNT_ZERO) & tx_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok_s   = push_req_s & ((count_q < CNT_FULL) | pop_s);

  // FIFO pointers/occupancy, sticky flags and run counter next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    stop_d = stop_q | (wr_req_s & is_io_s & (off_s == 3'd4));
    ovf_d  = ovf_q | (push_req_s & ~push_ok_s);
    if (bus.en_in) begin
      cnt_d = cnt_q + 32'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Read data path: d_out and snapshot only change on an enabled read.
  always_comb begin
    d_out_d  = d_out_q;
    rx_pop_d = 1'b0;
    snap_d   = snap_q;
    if (rd_req_s) begin
      if (is_io_s) begin
        case (off_s)
          3'd0: begin
            if (rx_valid) begin
              d_out_d  = rx_data;
              rx_pop_d = 1'b1;
            end else begin
              d_out_d  = 8'h00;
            end
          end
          3'd4: begin
            d_out_d = cnt_q[7:0];
            snap_d  = cnt_q;
          end
          3'd5:    d_out_d = snap_q[15:8];
          3'd6:    d_out_d = snap_q[23:16];
          3'd7:    d_out_d = snap_q[31:24];
          default: d_out_d = 8'h00;
        endcase
      end else begin
        d_out_d = ram_q[ram_addr_s];
      end
    end else begin
      d_out_d = d_out_q;
    end
  end

  // Control and status registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr_q  <= {PW{1'b0}};
      rd_ptr_q  <= {PW{1'b0}};
      count_q   <= CNT_ZERO;
      cnt_q     <= 32'h0000_0000;
      snap_q    <= 32'h0000_0000;
      d_out_q   <= 8'h00;
      rx_pop_q  <= 1'b0;
      io_full_q <= 1'b0;
      stop_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      cnt_q     <= cnt_d;
      snap_q    <= snap_d;
      d_out_q   <= d_out_d;
      rx_pop_q  <= rx_pop_d;
      // Registered from next-state so it tracks the current occupancy exactly.
      io_full_q <= (count_d >= CNT_NEAR);
      stop_q    <= stop_d;
      ovf_q     <= ovf_d;
    end
  end

  // Data storage without reset; FIFO contents are invalidated via the pointers.
  always_ff @(posedge clk_in) begin
    if (wr_req_s && !is_io_s) begin
      ram_q[ram_addr_s] <= bus.d_in;
    end
    if (push_ok_s) begin
      fifo_q[wr_ptr_q] <= push_byte_s;
    end
  end

  assign bus.d_out          = d_out_q;
  assign bus.io_buffer_full = io_full_q;
  assign rx_pop             = rx_pop_q;
  assign tx_valid           = (count_q != CNT_ZERO);
  assign tx_data            = fifo_q[rd_ptr_q];
  assign program_stop       = stop_q;
  assign tx_overflow        = ovf_q;

endmodule

// File: doc/mem_io_responder.md
# mem_io_responder

Target-side responder for the CPU's byte-wide memory bus: it serves every `mem_a`/`mem_wr`/`mem_dout` request with 128 KB of RAM plus the memory-mapped I/O window at 0x30000–0x30007. The I/O window covers UART RX/TX, a 32-bit run-cycle counter and a program-stop flag. It sits between the CPU top and the board UART, and it drives `mem_din` and `io_buffer_full` back to the CPU.

## Interface
- `RAM_AW`, default 17: RAM address width in bytes (128 KB).
- `TXQ_DEPTH`, default 8: TX FIFO entries; must be a power of 2 and ≥ 4.
- `clk_in`, input, 1: system clock.
- `rst_in`, input, 1: reset, asynchronous, active-low.
- `en_in`, input, 1: CPU running. When low, bus requests are ignored and the counter freezes.
- `a_in`, input, 32: request address (CPU `mem_a`).
- `d_in`, input, 8: write data (CPU `mem_dout`).
- `wr_in`, input, 1: 1 = write, 0 = read (CPU `mem_wr`).
- `d_out`, output, 8: read data (CPU `mem_din`), registered.
- `io_buffer_full`, output, 1: TX FIFO near-full.
- `rx_data`, input, 8: received UART byte.
- `rx_valid`, input, 1: `rx_data` holds an unread byte.
- `rx_pop`, output, 1: one-cycle pulse; the RX byte was consumed.
- `tx_data`, output, 8: head of the TX FIFO.
- `tx_valid`, output, 1: TX FIFO not empty.
- `tx_ready`, input, 1: UART accepts `tx_data` this cycle.
- `program_stop`, output, 1: sticky; the program requested a stop.
- `tx_overflow`, output, 1: sticky; an I/O write was dropped because the FIFO was full.

## Operation
- **Decode.** `a_in[17:16]==2'b11` selects I/O; otherwise the request goes to RAM at `a_in[RAM_AW-1:0]`. I/O offset is `a_in[2:0]`, and bits 15:3 are ignored.
- **RAM.** A read loads `ram[addr]` into `d_out`. A write stores `d_in`. RAM contents are not reset.
- **I/O reads:**
  - off 0: `d_out` is `rx_data` if `rx_valid`, else 0x00. `rx_pop` pulses only when `rx_valid`.
  - off 4: `d_out` is `cnt[7:0]`, and all of `cnt` is latched into `snap`.
  - off 5/6/7: `d_out` is `snap[15:8]`, `snap[23:16]`, `snap[31:24]` respectively, giving coherent multi-byte reads.
  - off 1–3: `d_out` is 0x00.
- **I/O writes:**
  - off 0: push `d_in` into the TX FIFO; 0x00 is ignored.
  - off 4: push 0x00 (stop marker) and set `program_stop`.
  - Any other offset: no effect.
  - I/O writes do not change `d_out`.
- **TX FIFO:**
  - Circular buffer with read/write pointers of width log2(`TXQ_DEPTH`), wrapping modulo depth, plus a count register.
  - `tx_valid = (count != 0)`. A pop happens when `tx_valid && tx_ready`.
  - A push is accepted if `count < TXQ_DEPTH`, or if a pop occurs in the same cycle.
  - A push that is not accepted is dropped and sets `tx_overflow`.
  - Drain runs regardless of `en_in`.
- **io_buffer_full** is `count >= TXQ_DEPTH-2`. The two-entry margin covers a write already in flight from the CPU.
- **Counter.** `cnt` is 32 bits and increments by 1 each cycle that `en_in` is high. It wraps 0xFFFFFFFF → 0.
- **Sticky flags.** `program_stop` and `tx_overflow` clear only on reset. RAM accesses continue to be served after a stop.

## Timing
- **Reset** (`rst_in` low, asynchronous) clears `d_out`, `rx_pop`, `io_buffer_full`, `program_stop`, `tx_overflow`, `cnt`, `snap`, the FIFO pointers and `count`. `tx_valid` is 0 during reset.
- **Read latency** is one cycle: a request sampled at edge N produces `d_out` valid after edge N (cycle N+1). `d_out` holds until the next read.
- **Write latency** is one cycle; there is no wait state. A RAM read in the cycle after a write to the same address returns the new byte.
- **en_in low:** no RAM/I/O access, `d_out` holds, `cnt` holds, `rx_pop` stays 0. TX drain still runs.
- **Simultaneous push and pop:**
  - With `count == TXQ_DEPTH`: both happen, and `count` is unchanged.
  - With `count == 0`: only the push happens; the pushed byte is visible on `tx_data` the next cycle.
- **Counter wrap:** `cnt` wraps silently.
- **Reset mid-operation:** FIFO contents are discarded, the in-flight read result is lost, and `d_out` is 0x00.

## Test plan
- **RAM read/write:** write 0xA5 to 0x00123, then read 0x00123 → `d_out` is 0xA5 one cycle later. Read 0x1FFFF after writing 0x3C there → 0x3C.
- **UART TX:** write 0x48 then 0x00 to 0x30000 with `tx_ready` held 0 → exactly one FIFO entry, `tx_data` is 0x48. Raise `tx_ready` → one pop, then `tx_valid` is 0.
- **FIFO full, depth 8, `tx_ready` 0:**
  - `io_buffer_full` rises when `count` reaches 6.
  - The 9th write sets `tx_overflow`; the FIFO keeps the first 8 bytes in order.
  - With `count` at 8, a write in the same cycle as a pop is accepted.
- **Counter snapshot:** preload `cnt` to 0x00FFFFFE, then read 0x30004–0x30007 on consecutive cycles → bytes 0xFE, 0xFF, 0xFF, 0x00, taken from the snapshot even though `cnt` crosses 0x01000000.
- **Stop:** write to 0x30004 → `program_stop` is 1 and a 0x00 byte appears on `tx_data`. A later RAM write/read still works.
- **RX and pause:**
  - With `rx_valid` 1 and `rx_data` 0x61, reading 0x30000 → `d_out` is 0x61 and `rx_pop` pulses once.
  - With `rx_valid` 0, the same read → `d_out` is 0x00 and `rx_pop` stays 0.
  - Drop `en_in` for 5 cycles → `cnt` unchanged and the TX drain continues.
